aom_overload_interlock: RTL

Safety interlock that consumes the AOM overload error flags (continuous and integral) and acts on the AOM drive path. On any error it trips: it forces the AOM voltage to a safe code, asserts the laser-out inhibit, and holds the fault for a minimum holdoff. It returns to normal operation only after an explicit host clear, once both error flags are low. It sits between the host laser-control registers and the AOM DAC driver, downstream of the overload detector.

---
 rtl/aom_overload_interlock.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aom_overload_interlock.sv
// Purpose: trips the AOM drive path to a safe code and inhibits the laser on any overload error, and stays latched until the host clears it.
// Latency: all outputs are registered. Error to inhibit takes 1 cycle. Host strobe pass-through in RUN takes 1 cycle.
// Backpressure: none. While faulted, host strobes are dropped rather than queued.
module aom_overload_interlock #(
  parameter real         TCQ            = 0.1,          // simulation-only clock-to-q; registers here are zero-delay
  parameter int unsigned HOLDOFF_CYCLES = 100_000_000,  // minimum HOLD duration, 1..2^32-1
  parameter int unsigned FAULT_CNT_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aom_trig_protect_i,
  input  logic                   aom_continuous_trig_err_i,
  input  logic                   aom_integral_trig_err_i,
  input  logic                   laser_aom_en_i,
  input  logic [11:0]            laser_aom_voltage_i,
  input  logic [11:0]            aom_safe_voltage_i,
  input  logic                   err_clear_i,
  output logic                   laser_aom_en_o,
  output logic [11:0]            laser_aom_voltage_o,
  output logic                   laser_out_inhibit_o,
  output logic [1:0]             fault_state_o,
  output logic [1:0]             fault_cause_o,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_TRIP     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_e;

  // Last value of the holdoff counter before HOLD may exit.
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  logic [11:0]            volt_q, volt_d;
  logic                   inhibit_q, inhibit_d;
  logic [1:0]             cause_q, cause_d;
  logic [FAULT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            hold_q, hold_d;

  logic [1:0] err_bits;
  logic       err_any;

  // bit0 continuous, bit1 integral; protect gates only new trips, not the clear check
  assign err_bits = {aom_integral_trig_err_i, aom_continuous_trig_err_i};
  assign err_any  = aom_trig_protect_i & (|err_bits);

  // Next-state and registered-output computation for the interlock FSM
  always_comb begin
    state_d   = state_q;
    en_d      = 1'b0;
    volt_d    = volt_q;
    inhibit_d = inhibit_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    unique case (state_q)
      ST_RUN: begin
        if (err_any) begin
          // trip wins over a same-cycle host strobe: the safe code is strobed instead
          state_d   = ST_TRIP;
          en_d      = 1'b1;
          volt_d    = aom_safe_voltage_i;
          inhibit_d = 1'b1;
          cause_d   = err_bits;
          if (cnt_q != {FAULT_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else begin
          en_d = laser_aom_en_i;
          if (laser_aom_en_i) volt_d = laser_aom_voltage_i;
        end
      end
      ST_TRIP: begin
        state_d = ST_HOLD;
        hold_d  = '0;
        if (err_any) cause_d = cause_q | err_bits;
      end
      ST_HOLD: begin
        if (err_any) begin
          // a fresh error restarts the holdoff but is not a new trip
          hold_d  = '0;
          cause_d = cause_q | err_bits;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT_CLR;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      ST_WAIT_CLR: begin
        if (err_clear_i && (err_bits == 2'b00)) begin
          state_d   = ST_RUN;
          inhibit_d = 1'b0;
          cause_d   = 2'b00;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      en_q      <= 1'b0;
      volt_q    <= '0;
      inhibit_q <= 1'b0;
      cause_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      volt_q    <= volt_d;
      inhibit_q <= inhibit_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
    end
  end

  assign laser_aom_en_o      = en_q;
  assign laser_aom_voltage_o = volt_q;
  assign laser_out_inhibit_o = inhibit_q;
  assign fault_state_o       = state_q;
  assign fault_cause_o       = cause_q;
  assign fault_cnt_o         = cnt_q;

endmodule
